video_scanout: RTL and testbench

Display-side reader of the dual-port video RAM. The ARM core writes pixels through RAM port a; this block owns port b, scans the framebuffer in raster order and emits a 640x480@60 VGA-style pixel stream (pixel, hsync, vsync, de) with integer upscaling. It also exposes a double-buffer base register latched once per frame and a vblank status the core can poll.

---
 rtl/video_scanout.sv | 145 ++++++++++++++
 tb/tb_video_scanout.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_scanout.sv
// video_scanout: raster-order reader of the video RAM (port b). Generates
// VGA-style timing, fetches framebuffer pixels with integer upscaling and
// emits pixel/hsync/vsync/de plus frame_start and vblank status.
// Pipeline: stage 0 counters, stage 1 rd_addr, stage 2 RAM q, stage 3 outputs.
module video_scanout #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int FB_W        = 160,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 16,
   parameter int PIX_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] fb_base,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic [PIX_W-1:0]  pixel,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              frame_start,
   output logic              vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   // Lines sharing one framebuffer row: the row advances after the last of them.
   localparam logic [VW-1:0]     ROW_MASK = VW'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

   // Per-pixel timing flags carried down the pipeline alongside the RAM read.
   typedef struct packed {
      logic active;
      logic hsync_n;
      logic vsync_n;
      logic first;
      logic blank;
   } flags_t;

   // Idle flags: not active, both syncs deasserted (high), no pulse, no blank.
   localparam flags_t FLAGS_IDLE = flags_t'(5'b01100);

   logic [HW-1:0]     h_q, h_d;
   logic [VW-1:0]     v_q, v_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [PIX_W-1:0]  pixel_q, pixel_d;
   flags_t            s0, s1_q, s2_q, out_q;
   logic              line_end, frame_end;

   // Stage 0: raster counters, row accumulator, frame-latched base, next read address.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
      h_d       = h_q;
      v_d       = v_q;
      row_d     = row_q;
      base_d    = base_q;
      rd_addr_d = rd_addr_q;
      s0        = FLAGS_IDLE;
      line_end  = (h_q == H_LAST);
      frame_end = line_end && (v_q == V_LAST);

      h_d = line_end ? '0 : h_q + HW'(1);
      if (line_end) begin
         v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end

      if (frame_end) begin
         row_d  = '0;
         base_d = fb_base;
      end else if (line_end && ((v_q & ROW_MASK) == ROW_MASK)) begin
         row_d = row_q + ROW_STEP;
      end

      s0.active  = (h_q < H_ACT) && (v_q < V_ACT);
      s0.hsync_n = !((h_q >= HS_START) && (h_q < HS_END));
      s0.vsync_n = !((v_q >= VS_START) && (v_q < VS_END));
      s0.first   = (h_q == '0) && (v_q == '0);
      s0.blank   = (v_q >= V_ACT);

      // Address arithmetic wraps modulo 2^ADDR_W; outside the active area the address holds.
      if (s0.active) begin
         rd_addr_d = base_q + row_q + ADDR_W'(h_q >> SCALE_SHIFT);
      end
   end

   // Stage 3 pixel select: RAM data inside the active area, black elsewhere.
   always_comb begin
      pixel_d = s2_q.active ? rd_data : '0;
   end

   // All state registers with synchronous reset; base is reloaded from fb_base while in reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         h_q       <= '0;
         v_q       <= '0;
         row_q     <= '0;
         base_q    <= fb_base;
         rd_addr_q <= '0;
         s1_q      <= FLAGS_IDLE;
         s2_q      <= FLAGS_IDLE;
         out_q     <= FLAGS_IDLE;
         pixel_q   <= '0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         row_q     <= row_d;
         base_q    <= base_d;
         rd_addr_q <= rd_addr_d;
         s1_q      <= s0;
         s2_q      <= s1_q;
         out_q     <= s2_q;
         pixel_q   <= pixel_d;
      end
   end

   assign rd_addr     = rd_addr_q;
   assign pixel       = pixel_q;
   assign hsync       = out_q.hsync_n;
   assign vsync       = out_q.vsync_n;
   assign de          = out_q.active;
   assign frame_start = out_q.first;
   assign vblank      = out_q.blank;

endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout: one full-size instance driven by a directed script
// and one small-geometry instance driven by random resets and base changes.
// A behavioural model computes expected outputs from raster position arithmetic.
module tb_video_scanout;

   localparam int NCYC = 30000;

   localparam int S_HA = 16, S_HFP = 2, S_HSY = 3, S_HBP = 3;
   localparam int S_VA = 12, S_VFP = 2, S_VSY = 2, S_VBP = 3;
   localparam int S_SH = 1, S_FBW = 8;

   localparam int HA  [2] = '{640, S_HA};
   localparam int HFP [2] = '{16, S_HFP};
   localparam int HSY [2] = '{96, S_HSY};
   localparam int HT  [2] = '{800, S_HA + S_HFP + S_HSY + S_HBP};
   localparam int VA  [2] = '{480, S_VA};
   localparam int VFP [2] = '{10, S_VFP};
   localparam int VSY [2] = '{2, S_VSY};
   localparam int VT  [2] = '{525, S_VA + S_VFP + S_VSY + S_VBP};
   localparam int FBW [2] = '{160, S_FBW};
   localparam int SH  [2] = '{2, S_SH};

   // {pixel, hsync, vsync, de, frame_start, vblank} at reset
   localparam logic [12:0] RST_BUNDLE = 13'b0000_0000_11000;

   logic        clk;
   logic        rst [2];
   logic [15:0] fbb [2];
   logic [15:0] rda [2];
   logic [7:0]  rdd [2];
   logic [7:0]  pix [2];
   logic        hs [2], vs [2], de [2], fs [2], vb [2];
   logic [7:0]  mem [65536];

   int checks, errors;
   int g;
   int bphase;
   int srcount;

   // model state per instance
   int          p [2];
   int          age [2];
   int          last_fs [2];
   logic [15:0] cur_base [2];
   logic [15:0] exp_rd [2];
   logic [15:0] ahist [2][4];

   video_scanout u_dut_full (
      .clk(clk), .reset(rst[0]), .fb_base(fbb[0]), .rd_addr(rda[0]), .rd_data(rdd[0]),
      .pixel(pix[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
      .frame_start(fs[0]), .vblank(vb[0])
   );

   video_scanout #(
      .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
      .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
      .FB_W(S_FBW), .SCALE_SHIFT(S_SH), .ADDR_W(16), .PIX_W(8)
   ) u_dut_small (
      .clk(clk), .reset(rst[1]), .fb_base(fbb[1]), .rd_addr(rda[1]), .rd_data(rdd[1]),
      .pixel(pix[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
      .frame_start(fs[1]), .vblank(vb[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM port b: q valid one cycle after the address
   always @(posedge clk) begin
      rdd[0] <= mem[rda[0]];
      rdd[1] <= mem[rda[1]];
   end

   task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, k, g, got, exp);
      end
   endtask

   function automatic bit act_at(input int k, input int pos);
      return ((pos % HT[k]) < HA[k]) && ((pos / HT[k]) < VA[k]);
   endfunction

   function automatic logic [15:0] addr_at(input int k, input int pos, input logic [15:0] base);
      int h, v;
      h = pos % HT[k];
      v = pos / HT[k];
      return 16'(int'(base) + (v >> SH[k]) * FBW[k] + (h >> SH[k]));
   endfunction

   function automatic logic [12:0] exp_bundle(input int k);
      int fl, q, h, v;
      logic d, hs_n, vs_n;
      logic [7:0] px;
      if (age[k] < 3) return RST_BUNDLE;
      fl   = HT[k] * VT[k];
      q    = (p[k] + fl - 3) % fl;
      h    = q % HT[k];
      v    = q / HT[k];
      d    = (h < HA[k]) && (v < VA[k]);
      hs_n = !((h >= HA[k] + HFP[k]) && (h < HA[k] + HFP[k] + HSY[k]));
      vs_n = !((v >= VA[k] + VFP[k]) && (v < VA[k] + VFP[k] + VSY[k]));
      px   = d ? mem[ahist[k][(g - 3) & 3]] : 8'h00;
      return {px, hs_n, vs_n, d, (q == 0), (v >= VA[k])};
   endfunction

   // advance the model by one clock edge using the inputs the DUT just sampled
   task automatic model_step(input int k);
      int fl;
      fl = HT[k] * VT[k];
      if (rst[k]) begin
         p[k]        = 0;
         age[k]      = 0;
         cur_base[k] = fbb[k];
         exp_rd[k]   = '0;
         last_fs[k]  = -1;
      end else begin
         if (act_at(k, p[k])) exp_rd[k] = addr_at(k, p[k], cur_base[k]);
         if (p[k] == fl - 1) cur_base[k] = fbb[k];
         p[k] = (p[k] + 1) % fl;
         if (age[k] < 1000000) age[k]++;
      end
      ahist[k][g & 3] = addr_at(k, p[k], cur_base[k]);
   endtask

   task automatic pins();
      int a;
      a = age[0];
      case (bphase)
         0: begin
            check("rst_rd_addr", 0, rda[0], 32'h0);
            check("rst_outputs", 0, {pix[0], hs[0], vs[0], de[0], fs[0], vb[0]}, RST_BUNDLE);
         end
         1: begin
            if (a == 0) check("rst_outputs", 0, {pix[0], hs[0], vs[0], de[0], fs[0], vb[0]}, RST_BUNDLE);
            if (a == 1) check("first_rd_addr", 0, rda[0], 32'h1000);
            if (a == 1) check("de_before_latency", 0, de[0], 1'b0);
            if (a == 3) check("de_first", 0, de[0], 1'b1);
            if (a == 3) check("frame_start_first", 0, fs[0], 1'b1);
            if (a == 4) check("frame_start_single", 0, fs[0], 1'b0);
            if (a >= 3 && a <= 14) check("upscaled_pixel", 0, pix[0], 32'((a - 3) >> 2));
            if (a == 642) check("de_last", 0, de[0], 1'b1);
            if (a == 643) check("de_fall", 0, de[0], 1'b0);
            if (a == 658) check("hsync_before", 0, hs[0], 1'b1);
            if (a == 659) check("hsync_start", 0, hs[0], 1'b0);
            if (a == 754) check("hsync_end", 0, hs[0], 1'b0);
            if (a == 755) check("hsync_after", 0, hs[0], 1'b1);
            if (a == 802) check("de_blank_line1", 0, de[0], 1'b0);
            if (a == 803) check("de_rise_line1", 0, de[0], 1'b1);
            if (a == 3201) check("line4_addr_base1000", 0, rda[0], 32'h10A0);
         end
         2: begin
            if (a == 3201) check("line4_addr_base0", 0, rda[0], 32'd160);
         end
         3: begin
            if (a == 0) check("midline_rst_rd_addr", 0, rda[0], 32'h0);
            if (a == 0) check("midline_rst_outputs", 0, {pix[0], hs[0], vs[0], de[0], fs[0], vb[0]}, RST_BUNDLE);
            if (a == 1) check("new_base_first_read", 0, rda[0], 32'h8000);
         end
         4: begin
            if (a == 64) check("addr_top", 0, rda[0], 32'hFFFF);
            if (a == 65) check("addr_wrap", 0, rda[0], 32'h0000);
         end
         default: ;
      endcase
   endtask

   task automatic drive_full();
      case (bphase)
         0: if (g == 2) begin fbb[0] = 16'h1000; bphase = 1; end
         1: begin
            if (age[0] == 0) rst[0] = 1'b0;
            if (age[0] == 3300) begin rst[0] = 1'b1; fbb[0] = 16'h0000; bphase = 2; end
         end
         2: begin
            if (age[0] == 0) rst[0] = 1'b0;
            if (age[0] == 4000) fbb[0] = 16'h8000;
            if (age[0] == 8299) begin rst[0] = 1'b1; bphase = 3; end
         end
         3: begin
            if (age[0] == 0) rst[0] = 1'b0;
            if (age[0] == 20) begin rst[0] = 1'b1; fbb[0] = 16'hFFF0; bphase = 4; end
         end
         default: if (age[0] == 0) rst[0] = 1'b0;
      endcase
   endtask

   task automatic drive_small();
      if (rst[1]) begin
         srcount--;
         if (srcount <= 0) rst[1] = 1'b0;
      end else if ($urandom_range(0, 2999) == 0) begin
         rst[1]  = 1'b1;
         srcount = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 39) == 0) begin
         if ($urandom_range(0, 3) == 0) fbb[1] = 16'($urandom_range(16'hFFC0, 16'hFFFF));
         else fbb[1] = 16'($urandom);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      g       = -1;
      bphase  = 0;
      srcount = 2;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h1000 + i] = 8'(i);
      for (int k = 0; k < 2; k++) begin
         rst[k]     = 1'b1;
         fbb[k]     = 16'h0000;
         last_fs[k] = -1;
      end

      repeat (NCYC) begin
         @(posedge clk);
         g++;
         model_step(0);
         model_step(1);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check("rd_addr", k, rda[k], exp_rd[k]);
            check("outputs", k, {pix[k], hs[k], vs[k], de[k], fs[k], vb[k]}, exp_bundle(k));
            if (age[k] >= 3 && fs[k] === 1'b1) begin
               if (last_fs[k] >= 0) check("frame_period", k, g - last_fs[k], HT[k] * VT[k]);
               last_fs[k] = g;
            end
         end
         pins();
         drive_full();
         drive_small();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
